nibble_adder_scheduler: RTL

Shares one registered 4-bit nibble adder between NUM_REQ requesters using round-robin arbitration. Each requester uses a valid/ready request handshake. The block returns a 4-bit wrapped sum, a carry flag and the requester ID through a single valid/ready response channel. It sits between the tile's input-decoding logic and the result path to uo_out, and it sequences every use of the adder.

---
 rtl/nibble_pkg.sv | 14 +
 rtl/nibble_adder_scheduler_rr_arbiter.sv | 30 +++
 rtl/nibble_adder_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// Shared types for the nibble adder scheduler: operand width, FSM states, nibble type.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/nibble_adder_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester above last_grant, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_idx
);

  int idx;

  // Scan from last_grant+1 so the most recent winner has the lowest priority.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = {ID_W{1'b0}};
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(idx);
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/nibble_adder_scheduler.sv
// One registered 4-bit adder shared by NUM_REQ requesters, round-robin arbitrated,
// with a single valid/ready response channel and a completed-operation counter.
module nibble_adder_scheduler
  import nibble_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*4-1:0]    req_a,
  input  logic [NUM_REQ*4-1:0]    req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [3:0]              resp_sum,
  output logic                    resp_carry,
  output logic [ID_W-1:0]         resp_id,
  output logic [CNT_W-1:0]        ops_count
);

  sched_state_t          state_q;
  nibble_t               op_a_q;
  nibble_t               op_b_q;
  logic [ID_W-1:0]       op_id_q;
  logic [ID_W-1:0]       last_grant_q;
  logic                  resp_valid_q;
  nibble_t               resp_sum_q;
  logic                  resp_carry_q;
  logic [ID_W-1:0]       resp_id_q;
  logic [CNT_W-1:0]      ops_count_q;

  logic                  grant_valid;
  logic [ID_W-1:0]       grant_idx;
  nibble_t               sel_a_d;
  nibble_t               sel_b_d;
  logic [NIBBLE_W:0]     sum_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Grant is offered only while idle; the handshake completes in that same cycle.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (state_q == IDLE && grant_valid) begin
      req_ready[grant_idx] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Operand mux for the granted requester and the shared 5-bit adder.
  always_comb begin
    sel_a_d = req_a[int'(grant_idx)*NIBBLE_W +: NIBBLE_W];
    sel_b_d = req_b[int'(grant_idx)*NIBBLE_W +: NIBBLE_W];
    sum_d   = {1'b0, op_a_q} + {1'b0, op_b_q};
  end

  // Scheduler FSM; last_grant moves only when a response is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_a_q       <= {NIBBLE_W{1'b0}};
      op_b_q       <= {NIBBLE_W{1'b0}};
      op_id_q      <= {ID_W{1'b0}};
      last_grant_q <= ID_W'(NUM_REQ - 1);
      resp_valid_q <= 1'b0;
      resp_sum_q   <= {NIBBLE_W{1'b0}};
      resp_carry_q <= 1'b0;
      resp_id_q    <= {ID_W{1'b0}};
      ops_count_q  <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            op_a_q  <= sel_a_d;
            op_b_q  <= sel_b_d;
            op_id_q <= grant_idx;
            state_q <= EXEC;
          end else begin
            state_q <= IDLE;
          end
        end
        EXEC: begin
          resp_sum_q   <= sum_d[NIBBLE_W-1:0];
          resp_carry_q <= sum_d[NIBBLE_W];
          resp_id_q    <= op_id_q;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            last_grant_q <= resp_id_q;
            ops_count_q  <= ops_count_q + CNT_W'(1);
            state_q      <= IDLE;
          end else begin
            state_q <= RESP;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_sum   = resp_sum_q;
  assign resp_carry = resp_carry_q;
  assign resp_id    = resp_id_q;
  assign ops_count  = ops_count_q;

endmodule
